mdu_div_iter: RTL

//  Parametrised iterative non-restoring divider for the RV32 M-extension
//  (DIV/DIVU/REM/REMU); generational successor to the fixed 32-bit
//  non-restoring divider.

---
 rtl/div_pkg.sv | 30 +++
 rtl/nr_div_step.sv | 28 ++
 rtl/mdu_div_iter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared op encodings, FSM states and helpers for the M-ext divider
// Revision : 1.0
// ============================================================================
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_CORR = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nr_div_step.sv
`default_nettype none
// ============================================================================
// Module   : nr_div_step
// Brief    : One combinational non-restoring division iteration
// Revision : 1.0
// ============================================================================
module nr_div_step #(
    parameter int DW = 32
) (
    input  logic [DW:0]   rem_in,
    input  logic [DW-1:0] q_in,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   rem_out,
    output logic [DW-1:0] q_out
);

    logic [DW:0] w_shift;
    logic [DW:0] w_div_ext;

    // The remainder stays within [-D, D), so wrapping the doubled value to
    // DW+1 bits still yields the exact result after the add/subtract.
    assign w_shift   = {rem_in[DW-1:0], q_in[DW-1]};
    assign w_div_ext = {1'b0, divisor};
    assign rem_out   = rem_in[DW] ? (w_shift + w_div_ext) : (w_shift - w_div_ext);
    assign q_out     = {q_in[DW-2:0], ~rem_out[DW]};

endmodule
`default_nettype wire

// File: rtl/mdu_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_iter
// Brief    : Iterative non-restoring RV32M divider (DIV/DIVU/REM/REMU).
//            Define DIV_FAST_SPECIAL_EN to let divide-by-zero and overflow
//            skip the iteration phase.
// Revision : 1.0
// ============================================================================
module mdu_div_iter
    import div_pkg::*;
#(
    parameter int DW     = 32,
    parameter int UNROLL = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          flush,
    input  logic [1:0]    op,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          div_zero
);

    localparam int              c_STEPS    = DW / UNROLL;
    localparam int              c_CW       = $clog2(c_STEPS);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_STEPS - 1);
    localparam logic [DW-1:0]   c_MIN      = {1'b1, {(DW-1){1'b0}}};

    div_state_t      r_state, w_next;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_op;
    logic [DW-1:0]   r_a, r_q, r_div, r_result;
    logic [DW:0]     r_rem;
    logic            r_neg_q, r_neg_r, r_dz, r_ovf;

    logic            w_accept, w_sgn, w_a_neg, w_b_neg, w_b_zero, w_ovf_in, w_fast;
    logic [DW-1:0]   w_abs_a, w_abs_b, w_rem_mag, w_quo, w_remd, w_final;
    logic [DW:0]     w_rem [0:UNROLL];
    logic [DW-1:0]   w_q   [0:UNROLL];

    assign w_accept = (r_state == ST_IDLE) && start && !flush;
    assign w_sgn    = is_signed_op(op);
    assign w_a_neg  = w_sgn && dividend[DW-1];
    assign w_b_neg  = w_sgn && divisor[DW-1];
    assign w_abs_a  = w_a_neg ? (~dividend + 1'b1) : dividend;
    assign w_abs_b  = w_b_neg ? (~divisor + 1'b1) : divisor;
    assign w_b_zero = (divisor == '0);
    assign w_ovf_in = w_sgn && (dividend == c_MIN) && (divisor == '1);

`ifdef DIV_FAST_SPECIAL_EN
    assign w_fast = w_b_zero || w_ovf_in;
`else
    assign w_fast = 1'b0;
`endif

    assign w_rem[0] = r_rem;
    assign w_q[0]   = r_q;

    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_unroll
        nr_div_step #(.DW(DW)) u_step (
            .rem_in  (w_rem[gi]),
            .q_in    (w_q[gi]),
            .divisor (r_div),
            .rem_out (w_rem[gi+1]),
            .q_out   (w_q[gi+1])
        );
    end

    // Quotient bits are exact; only a negative remainder needs one add-back.
    assign w_rem_mag = r_rem[DW] ? (r_rem[DW-1:0] + r_div) : r_rem[DW-1:0];
    assign w_quo     = r_neg_q ? (~r_q + 1'b1) : r_q;
    assign w_remd    = r_neg_r ? (~w_rem_mag + 1'b1) : w_rem_mag;

    always_comb begin
        w_final = is_rem_op(r_op) ? w_remd : w_quo;
        if (r_dz) begin
            w_final = is_rem_op(r_op) ? r_a : '1;
        end else if (r_ovf) begin
            w_final = is_rem_op(r_op) ? '0 : c_MIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_fast ? ST_CORR : ST_CALC;
            ST_CALC: if (r_cnt == '0) w_next = ST_CORR;
            ST_CORR: w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (flush) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_q      <= '0;
            r_div    <= '0;
            r_rem    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt   <= c_CNT_LAST;
            r_op    <= op;
            r_a     <= dividend;
            r_q     <= w_abs_a;
            r_div   <= w_abs_b;
            r_rem   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= w_b_zero;
            r_ovf   <= w_ovf_in;
        end else if (r_state == ST_CALC) begin
            r_rem <= w_rem[UNROLL];
            r_q   <= w_q[UNROLL];
            r_cnt <= r_cnt - c_CW'(1);
        end else if ((r_state == ST_CORR) && !flush) begin
            r_result <= w_final;
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE) && !flush;
    assign div_zero = done && r_dz;
    assign result   = r_result;

endmodule
`default_nettype wire
